// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Each bit lasts 16 ticks of a divided clock; cts_n only gates acceptance of a new frame.
module uart_tx #(
  parameter int BAUD_RATE     = 115200,
  parameter int FREQUENCY_CLK = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       cts_n,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int DIV   = FREQUENCY_CLK / (16 * BAUD_RATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'((DIV > 1) ? (DIV - 2) : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [1:0]       data_bits_q;
  logic             stop_q;
  logic             parity_en_q;
  logic             parity_q;
  logic             stop_cnt;

  logic             tick;
  logic             bit_end;
  logic             final_next;
  logic             accept;
  logic [2:0]       last_idx;
  logic [7:0]       data_mask;
  logic             even_parity;

  assign data_mask   = 8'hFF >> (3'd3 - {1'b0, data_bit_num});
  assign even_parity = ^(tx_data & data_mask);
  assign last_idx    = 3'd4 + {1'b0, data_bits_q};
  assign accept      = tx_start && !cts_n && !tx_done;

  assign tick    = (div_cnt == DIV_LAST);
  assign bit_end = tick && (tick_cnt == 4'd15);

  // The last stop bit hands over to IDLE one clock early so that the tx_done
  // cycle itself is the final clock of the frame.
  assign final_next = (DIV > 1) ? ((tick_cnt == 4'd15) && (div_cnt == DIV_PRE))
                                : (tick_cnt == 4'd14);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_bits_q <= '0;
      stop_q      <= 1'b0;
      parity_en_q <= 1'b0;
      parity_q    <= 1'b0;
      stop_cnt    <= 1'b0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          tick_cnt <= tick_cnt + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          div_cnt  <= '0;
          tick_cnt <= '0;
          if (accept) begin
            shift       <= tx_data & data_mask;
            data_bits_q <= data_bit_num;
            stop_q      <= stop_bit_num;
            parity_en_q <= parity_en;
            parity_q    <= parity_type ? even_parity : ~even_parity;
            state       <= START;
            tx          <= 1'b0;
            tx_busy     <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == last_idx) begin
              if (parity_en_q) begin
                state <= PARITY;
                tx    <= parity_q;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (stop_cnt == stop_q) begin
            if (final_next) begin
              state    <= IDLE;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              div_cnt  <= '0;
              tick_cnt <= '0;
            end
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at default parameters (432 clocks per bit).
// Frames are sampled mid-bit; expected bit patterns are written out by hand (bit 0 = start bit).
module tb_uart_tx;

  localparam int BIT  = 432;
  localparam int HALF = 216;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] data_bit_num = 2'b11;
  logic       stop_bit_num = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       cts_n = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  int cyc = 0;
  int assertCount = 0;
  int failCount = 0;

  uart_tx #(
    .BAUD_RATE    (115200),
    .FREQUENCY_CLK(50000000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_bit_num(data_bit_num),
    .stop_bit_num(stop_bit_num),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .cts_n       (cts_n),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] dbits, input logic sbits, input logic pen,
                               input logic ptype, input logic [7:0] data, input bit pulse);
    repeat (2) @(negedge clk);
    data_bit_num = dbits;
    stop_bit_num = sbits;
    parity_en    = pen;
    parity_type  = ptype;
    tx_data      = data;
    if (pulse) begin
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
    end
  endtask

  task automatic waitStart(output int t0, output bit found);
    found = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 3000; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        t0 = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // midAction at bit 2: 1 = pulse tx_start, 2 = change tx_data to 0x42, 3 = drop tx_start
  task automatic receiveFrame(input string tag, input int nbits, input logic [11:0] expBits,
                              input int midAction, output int t0, output int td);
    bit found;
    int skip;
    waitStart(t0, found);
    checkOutput({tag, " start"}, 32'(found), 32'd1);
    td = t0;
    if (!found) return;
    skip = 0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) repeat (BIT - skip) @(negedge clk);
      skip = 0;
      checkOutput($sformatf("%s bit%0d", tag, k), 32'(tx), 32'(expBits[k]));
      checkOutput($sformatf("%s busy%0d", tag, k), 32'(tx_busy), 32'd1);
      if (k == 2) begin
        case (midAction)
          1: begin
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            skip = 1;
          end
          2: tx_data = 8'h42;
          3: tx_start = 1'b0;
          default: ;
        endcase
      end
    end
    found = 1'b0;
    for (int i = 0; i < BIT; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    td = cyc;
    checkOutput({tag, " done seen"}, 32'(found), 32'd1);
    checkOutput({tag, " length"}, 32'(td - t0 + 1), 32'(nbits * BIT));
    checkOutput({tag, " busy at done"}, 32'(tx_busy), 32'd0);
    checkOutput({tag, " tx at done"}, 32'(tx), 32'd1);
  endtask

  initial begin
    int t0, td, t0b, tdb, cX;
    bit found, flag;

    repeat (3) @(negedge clk);
    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset busy", 32'(tx_busy), 32'd0);
    checkOutput("reset done", 32'(tx_done), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle tx", 32'(tx), 32'd1);

    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1);
    receiveFrame("8N1 0x55", 10, 12'h2AA, 0, t0, td);

    applyStimulus(2'b10, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    receiveFrame("7E2 0xFF", 11, 12'h7FE, 0, t0, td);

    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1);
    receiveFrame("5O1 0x03", 8, 12'h0C6, 0, t0, td);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1);
    receiveFrame("5E1 0x03", 8, 12'h086, 0, t0, td);

    // Flow control: request held while cts_n is high must not start a frame.
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
    cts_n = 1'b1;
    tx_start = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) flag = 1'b1;
    end
    checkOutput("cts blocked", 32'(flag), 32'd0);
    cts_n = 1'b0;
    cX = cyc;
    @(negedge clk);
    tx_start = 1'b0;
    receiveFrame("cts 0x3C", 10, 12'h278, 1, t0, td);
    checkOutput("cts start delay", 32'(t0 - cX), 32'd1);
    flag = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) flag = 1'b1;
    end
    checkOutput("no extra frame", 32'(flag), 32'd0);

    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0);
    tx_start = 1'b1;
    receiveFrame("b2b first 0x81", 10, 12'h302, 2, t0, td);
    receiveFrame("b2b second 0x42", 10, 12'h284, 3, t0b, tdb);
    checkOutput("b2b gap", 32'(t0b - td), 32'd2);

    // Reset in the middle of data bit 3 (a 0 for 0xF0) must force the line high at once.
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b1);
    waitStart(t0, found);
    checkOutput("rst frame start", 32'(found), 32'd1);
    repeat (4 * BIT + HALF) @(negedge clk);
    checkOutput("pre-reset bit3", 32'(tx), 32'd0);
    checkOutput("pre-reset busy", 32'(tx_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset tx", 32'(tx), 32'd1);
    checkOutput("async reset busy", 32'(tx_busy), 32'd0);
    checkOutput("async reset done", 32'(tx_done), 32'd0);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done !== 1'b0) flag = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1) flag = 1'b1;
    end
    checkOutput("abandoned frame quiet", 32'(flag), 32'd0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);
    receiveFrame("post-reset 0xA5", 10, 12'h34A, 0, t0, td);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
